// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO registers.
// Multiplies and divides run for a fixed number of busy cycles timed by a
// down-counter; the result is computed from operands latched at launch and
// committed to HI/LO on the edge that drops busy.

`ifndef MDU_OPS_SVH
`define MDU_OPS_SVH
`define MD_NONE  4'd0
`define MD_MULT  4'd1
`define MD_MULTU 4'd2
`define MD_DIV   4'd3
`define MD_DIVU  4'd4
`define MD_MFHI  4'd5
`define MD_MFLO  4'd6
`define MD_MTHI  4'd7
`define MD_MTLO  4'd8
`endif

// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no operation in flight; accepts launches and MTHI/MTLO writes
// S_BUSY  | mult/div in flight; counter runs down, commit when it reads 0

module mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       mduOp,
  input  logic             start,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mduRes
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic             is_mult;
  logic             is_div;
  logic             accept;

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   b_mag_safe;
  logic [WIDTH-1:0]   b_safe;
  logic [WIDTH-1:0]   sq_mag;
  logic [WIDTH-1:0]   sr_mag;
  logic [WIDTH-1:0]   s_quo;
  logic [WIDTH-1:0]   s_rem;
  logic [WIDTH-1:0]   u_quo;
  logic [WIDTH-1:0]   u_rem;
  logic               b_zero;

  // Decode the requested operation; anything is ignored while busy.
  always_comb begin
    is_mult = (mduOp == `MD_MULT) || (mduOp == `MD_MULTU);
    is_div  = (mduOp == `MD_DIV)  || (mduOp == `MD_DIVU);
    accept  = start && (state == S_IDLE);
  end

  // Result datapath, fed only from the latched operands.
  always_comb begin
    prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    b_zero     = (b_q == '0);
    a_mag      = a_q[WIDTH-1] ? (~a_q + 1'b1) : a_q;
    b_mag      = b_q[WIDTH-1] ? (~b_q + 1'b1) : b_q;
    // Substitute 1 for a zero divisor so the dividers never see x/0;
    // the commit is suppressed in that case anyway.
    b_mag_safe = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    b_safe     = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_q;

    sq_mag = a_mag / b_mag_safe;
    sr_mag = a_mag % b_mag_safe;
    // Quotient truncates toward zero; remainder follows the dividend sign.
    // Most-negative / -1 wraps to most-negative with remainder 0.
    s_quo  = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? (~sq_mag + 1'b1) : sq_mag;
    s_rem  = a_q[WIDTH-1] ? (~sr_mag + 1'b1) : sr_mag;

    u_quo  = a_q / b_safe;
    u_rem  = a_q % b_safe;
  end

  // Sequencer: launch, count down, commit; reset aborts with no commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      op_q  <= `MD_NONE;
      a_q   <= '0;
      b_q   <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && is_mult) begin
            state <= S_BUSY;
            busy  <= 1'b1;
            cnt   <= CW'(MULT_CYCLES - 1);
            op_q  <= mduOp;
            a_q   <= srcA;
            b_q   <= srcB;
          end else if (accept && is_div) begin
            state <= S_BUSY;
            busy  <= 1'b1;
            cnt   <= CW'(DIV_CYCLES - 1);
            op_q  <= mduOp;
            a_q   <= srcA;
            b_q   <= srcB;
          end else if (accept && (mduOp == `MD_MTHI)) begin
            hi_r <= srcA;
          end else if (accept && (mduOp == `MD_MTLO)) begin
            lo_r <= srcA;
          end
        end
        S_BUSY: begin
          if (cnt == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            case (op_q)
              `MD_MULT: begin
                hi_r <= prod_s[2*WIDTH-1:WIDTH];
                lo_r <= prod_s[WIDTH-1:0];
              end
              `MD_MULTU: begin
                hi_r <= prod_u[2*WIDTH-1:WIDTH];
                lo_r <= prod_u[WIDTH-1:0];
              end
              `MD_DIV: begin
                if (!b_zero) begin
                  hi_r <= s_rem;
                  lo_r <= s_quo;
                end
              end
              `MD_DIVU: begin
                if (!b_zero) begin
                  hi_r <= u_rem;
                  lo_r <= u_quo;
                end
              end
              default: begin
                hi_r <= hi_r;
                lo_r <= lo_r;
              end
            endcase
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Architectural registers are visible directly; read port is combinational.
  always_comb begin
    hi = hi_r;
    lo = lo_r;
    if (mduOp == `MD_MFHI)
      mduRes = hi_r;
    else if (mduOp == `MD_MFLO)
      mduRes = lo_r;
    else
      mduRes = '0;
  end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu at WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10.
module tb_mdu;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mduOp;
  logic        start;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mduRes;

  int n_cmp = 0;
  int n_err = 0;
  int n_busy;

  mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .mduOp  (mduOp),
    .start  (start),
    .srcA   (srcA),
    .srcB   (srcB),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo),
    .mduRes (mduRes)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    mduOp = op;
    srcA  = a;
    srcB  = b;
    tick();
    start = 1'b0;
    mduOp = OP_NONE;
  endtask

  // Counts cycles with busy high, starting at the first cycle after launch.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    mduOp = OP_NONE;
    srcA  = '0;
    srcB  = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);

    // MULT; busy must not reflect the launch in the launch cycle
    start = 1'b1; mduOp = OP_MULT; srcA = 32'hFFFF_FFFE; srcB = 32'd3;
    #1;
    chk("launch_not_comb", {63'd0, busy}, 64'd0);
    tick();
    start = 1'b0; mduOp = OP_NONE;
    chk("mult_busy_set", {63'd0, busy}, 64'd1);
    // operand change and MTLO during busy are both ignored
    srcA = 32'h1234_5678; srcB = 32'h9999_9999;
    issue(OP_MTLO, 32'h5, 32'h0);
    chk("mult_no_partial_lo", {32'd0, lo}, 64'd0);
    chk("mult_no_partial_hi", {32'd0, hi}, 64'd0);
    wait_idle(n_busy);
    chk("mult_busy_cycles", 64'(n_busy + 1), 64'd5);
    chk("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    chk("mult_lo", {32'd0, lo}, 64'hFFFF_FFFA);

    // MULTU
    issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n_busy);
    chk("multu_busy_cycles", 64'(n_busy), 64'd5);
    chk("multu_hi", {32'd0, hi}, 64'h2);
    chk("multu_lo", {32'd0, lo}, 64'hFFFF_FFFA);

    // MTLO after busy falls, read back via MFLO
    start = 1'b1; mduOp = OP_MTLO; srcA = 32'h5;
    #1;
    chk("mtlo_mdures_other_op", {32'd0, mduRes}, 64'd0);
    chk("mtlo_lo_before_edge", {32'd0, lo}, 64'hFFFF_FFFA);
    tick();
    start = 1'b0; mduOp = OP_MFLO;
    #1;
    chk("mflo_new", {32'd0, mduRes}, 64'h5);
    mduOp = OP_MFHI;
    #1;
    chk("mfhi", {32'd0, mduRes}, 64'h2);
    // MFLO with start and an MTLO-free cycle: read is independent of start
    start = 1'b1; mduOp = OP_MFLO; srcA = 32'hAAAA_AAAA;
    tick();
    start = 1'b0;
    chk("mflo_start_no_write", {32'd0, mduRes}, 64'h5);
    mduOp = OP_NONE;

    // DIV then DIVU launched in the first idle cycle
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n_busy);
    chk("div_busy_cycles", 64'(n_busy), 64'd10);
    chk("div_lo", {32'd0, lo}, 64'hFFFF_FFFD);
    chk("div_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    issue(OP_DIVU, 32'd7, 32'd2);
    chk("b2b_busy_set", {63'd0, busy}, 64'd1);
    chk("b2b_first_intact_lo", {32'd0, lo}, 64'hFFFF_FFFD);
    wait_idle(n_busy);
    chk("divu_busy_cycles", 64'(n_busy), 64'd10);
    chk("divu_lo", {32'd0, lo}, 64'd3);
    chk("divu_hi", {32'd0, hi}, 64'd1);

    // Most-negative / -1
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n_busy);
    chk("divovf_lo", {32'd0, lo}, 64'h8000_0000);
    chk("divovf_hi", {32'd0, hi}, 64'd0);

    // Divide by zero leaves HI/LO untouched
    issue(OP_MTHI, 32'h11, 32'd0);
    issue(OP_MTLO, 32'h22, 32'd0);
    issue(OP_DIVU, 32'd7, 32'd0);
    wait_idle(n_busy);
    chk("div0_busy_cycles", 64'(n_busy), 64'd10);
    chk("div0_hi", {32'd0, hi}, 64'h11);
    chk("div0_lo", {32'd0, lo}, 64'h22);

    // Undefined op code behaves as no-op
    issue(4'd9, 32'hDEAD_BEEF, 32'd1);
    chk("undef_busy", {63'd0, busy}, 64'd0);
    chk("undef_hi", {32'd0, hi}, 64'h11);

    // Reset in cycle 3 of a MULT aborts with no commit
    issue(OP_MULT, 32'd3, 32'd4);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hi", {32'd0, hi}, 64'd0);
    chk("abort_lo", {32'd0, lo}, 64'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("abort_no_late_lo", {32'd0, lo}, 64'd0);
    chk("abort_no_late_busy", {63'd0, busy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter WIDTH, default 32: operand, HI, LO and result width in bits; legal values 8 to 64.
REQ-002 Parameter MULT_CYCLES, default 5: busy duration of MULT/MULTU in cycles; legal minimum is 1.
REQ-003 Parameter DIV_CYCLES, default 10: busy duration of DIV/DIVU in cycles; legal minimum is 1.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port mduOp, input, 4 bits: operation select, encoded per REQ-008.
REQ-007 Port start, input, 1 bit: qualifies mduOp for the current cycle.
REQ-008 mduOp encodings SHALL be defined in the shared macro header:
- MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MFHI=5, MD_MFLO=6, MD_MTHI=7, MD_MTLO=8.
- All other values behave as MD_NONE.
REQ-009 Port srcA, input, WIDTH bits: multiplicand or dividend; MTHI/MTLO write data.
REQ-010 Port srcB, input, WIDTH bits: multiplier or divisor.
REQ-011 Port busy, output, 1 bit: high while a multiply or divide is in flight.
REQ-012 Port hi, output, WIDTH bits: architectural HI register.
REQ-013 Port lo, output, WIDTH bits: architectural LO register.
REQ-014 Port mduRes, output, WIDTH bits: read data for MFHI/MFLO.

Function
REQ-015 Launch: start=1 with MULT/MULTU/DIV/DIVU while busy=0 SHALL latch srcA, srcB and the op at that edge.
REQ-016 Busy timing for a launch at edge t: busy SHALL be 1 for exactly N cycles, where N is MULT_CYCLES or DIV_CYCLES; HI/LO SHALL update at the edge that drops busy.
REQ-017 A launch SHALL NOT be combinationally reflected on busy in the launch cycle; the stall unit ORs start with busy.
REQ-018 An internal down-counter SHALL load N-1 on launch, decrement while busy, and release busy and commit when it reads 0.
REQ-019 MULT: signed 2*WIDTH product; HI gets the upper WIDTH bits, LO the lower WIDTH bits. MULTU: same split, unsigned.
REQ-020 DIV, signed: LO gets the quotient truncated toward zero; HI gets the remainder, carrying the sign of the dividend.
REQ-021 DIV with dividend = most-negative value and divisor = -1: LO gets the most-negative value, HI gets 0.
REQ-022 DIVU: unsigned; LO gets the quotient, HI gets the remainder.
REQ-023 Divisor 0 (DIV or DIVU): busy SHALL still run the full DIV_CYCLES; HI and LO SHALL be left unchanged at commit.
REQ-024 Operands are latched at launch; srcA/srcB changes while busy SHALL NOT affect the result.
REQ-025 Any start with busy=1 SHALL be ignored: no launch, no MTHI/MTLO write, counter undisturbed.
REQ-026 MTHI (start=1, busy=0) SHALL write srcA into HI at the edge; MTLO likewise into LO.
REQ-027 mduRes SHALL be combinational: hi when mduOp=MD_MFHI, lo when MD_MFLO, otherwise 0, regardless of start or busy.
REQ-028 hi and lo outputs SHALL always show the current register contents and SHALL NOT show partial results.
REQ-029 A second launch SHALL be accepted in the cycle after busy falls; back-to-back operations carry no bubble penalty.

Reset
REQ-030 Reset=1 at an edge SHALL clear HI, LO, the counter and busy to 0 and discard latched operands; this takes priority over all inputs.
REQ-031 Reset during a busy operation SHALL abort it with no commit; busy=0 in the following cycle.

Verification
REQ-032 Cover these directed scenarios (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10):
- MULT with srcA=0xFFFFFFFE, srcB=3 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV with srcA=-7, srcB=2 -> busy high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with srcA=7, srcB=2 -> LO=3, HI=1.
- DIV with srcA=0x80000000, srcB=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU with srcB=0 after MTHI 0x11 and MTLO 0x22 -> HI=0x11, LO=0x22 unchanged after 10 busy cycles.
- MTLO 0x5 during busy -> ignored; LO equals the committed product. MTLO 0x5 after busy falls -> LO=0x5; MFLO in the same cycle -> mduRes shows the old LO, and 0x5 from the next cycle.
- Reset asserted in cycle 3 of a MULT -> busy=0 next cycle; HI=LO=0; no later commit.
- Second launch in the cycle busy falls -> accepted; busy high again for the full count; first result committed intact.
